// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard control slice: FSM state encoding and
// register-index type with the hard-wired zero register constant.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_sequencer_if.sv
// Hazard inputs and pipeline-control outputs of the sequencer.
// Optional PIPE_PERF_CNT_EN adds the three 32-bit performance counters.
interface pipe_hazard_sequencer_if;
    import pipe_ctrl_pkg::*;

    reg_idx_t    IF_ID_rs1;
    reg_idx_t    IF_ID_rs2;
    reg_idx_t    ID_EX_rd;
    logic        ID_EX_memRead;
    logic        EX_branch_taken;
    logic        dmem_req;
    logic        dmem_ready;

    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        mem_timeout;
    logic [1:0]  state_dbg;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic [31:0] freeze_cycles;

    modport master (
        output IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_memRead,
               EX_branch_taken, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_bubble, mem_timeout, state_dbg,
               stall_cycles, flush_count, freeze_cycles
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_memRead,
               EX_branch_taken, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_bubble, mem_timeout, state_dbg,
               stall_cycles, flush_count, freeze_cycles
    );
`else
    modport master (
        output IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_memRead,
               EX_branch_taken, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_bubble, mem_timeout, state_dbg
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_memRead,
               EX_branch_taken, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_bubble, mem_timeout, state_dbg
    );
`endif

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare: the load in EX writes a register
// that the instruction in ID reads. Writes to x0 never create a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    input  reg_idx_t i_ex_rd,
    input  logic     i_ex_mem_read,
    output logic     o_load_use
);

    assign o_load_use = i_ex_mem_read && (i_ex_rd != X0) &&
                        ((i_rs1 == i_ex_rd) || (i_rs2 == i_ex_rd));

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer: memory freeze > branch flush > load-use stall, with a
// memory-wait FSM and sticky timeout. PIPE_PERF_CNT_EN adds perf counters.
module pipe_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_hazard_sequencer_if.slave  hz_if
);

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;

    logic                w_load_use;
    logic                w_freeze;
    logic                w_hold_all;
    logic                w_flush;
    logic                w_stall;
    logic                w_limit;
    logic [WAIT_W-1:0]   w_frozen_total;

    load_use_detect u_load_use_detect (
        .i_rs1         (hz_if.IF_ID_rs1),
        .i_rs2         (hz_if.IF_ID_rs2),
        .i_ex_rd       (hz_if.ID_EX_rd),
        .i_ex_mem_read (hz_if.ID_EX_memRead),
        .o_load_use    (w_load_use)
    );

    // w_frozen_total counts frozen cycles of this access including the current one.
    always_comb begin
        w_freeze = ((r_state == RUN) && hz_if.dmem_req && !hz_if.dmem_ready) ||
                   ((r_state == MEM_WAIT) && !hz_if.dmem_ready);
        if (r_state == RUN)
            w_frozen_total = WAIT_W'(1);
        else if (r_wait_cnt == {WAIT_W{1'b1}})
            w_frozen_total = r_wait_cnt;
        else
            w_frozen_total = r_wait_cnt + WAIT_W'(1);
        w_limit    = (w_frozen_total >= WAIT_W'(MAX_WAIT));
        w_hold_all = rst || (r_state == TIMEOUT) || w_freeze;
        w_flush    = !w_hold_all && hz_if.EX_branch_taken;
        w_stall    = !w_hold_all && !hz_if.EX_branch_taken && w_load_use;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_freeze) begin
                        r_state    <= w_limit ? TIMEOUT : MEM_WAIT;
                        r_wait_cnt <= w_frozen_total;
                    end
                end
                MEM_WAIT: begin
                    if (hz_if.dmem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        r_state    <= w_limit ? TIMEOUT : MEM_WAIT;
                        r_wait_cnt <= w_frozen_total;
                    end
                end
                TIMEOUT: r_state <= TIMEOUT;
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign hz_if.pc_en        = !w_hold_all && !w_stall;
    assign hz_if.if_id_en     = !w_hold_all && !w_stall;
    assign hz_if.id_ex_en     = !w_hold_all;
    assign hz_if.ex_mem_en    = !w_hold_all;
    assign hz_if.mem_wb_en    = !w_hold_all;
    assign hz_if.if_id_flush  = w_flush;
    assign hz_if.id_ex_bubble = w_flush || w_stall;
    assign hz_if.mem_timeout  = !rst && (r_state == TIMEOUT);
    assign hz_if.state_dbg    = rst ? RUN : r_state;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic [31:0] r_freeze_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_flush_count   <= '0;
            r_freeze_cycles <= '0;
        end else begin
            if (w_stall)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_flush)
                r_flush_count <= r_flush_count + 32'd1;
            if (w_hold_all)
                r_freeze_cycles <= r_freeze_cycles + 32'd1;
        end
    end

    assign hz_if.stall_cycles  = r_stall_cycles;
    assign hz_if.flush_count   = r_flush_count;
    assign hz_if.freeze_cycles = r_freeze_cycles;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Scoreboard bench for pipe_hazard_sequencer: directed scenarios followed by
// random hazard traffic, each cycle checked against a behavioural model.
module tb_pipe_hazard_sequencer;

    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_sequencer_if hz();

    pipe_hazard_sequencer #(.WAIT_W(8), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_if (hz)
    );

    typedef struct {
        logic [4:0]  en;      // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic        flush;
        logic        bubble;
        logic        tmo;
        logic [1:0]  st;
        logic [31:0] stl;
        logic [31:0] fl;
        logic [31:0] frz;
        string       tag;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Model: is the memory hung, is an access outstanding, how long frozen so far.
    bit          m_hung = 0;
    bit          m_waiting = 0;
    int          m_frozen = 0;
    logic [31:0] m_stl = 0;
    logic [31:0] m_fl = 0;
    logic [31:0] m_frz = 0;

    function automatic void chk(input string name, input string tag,
                                input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%s] t=%0t: got %0h, expected %0h", name, tag, $time, act, exp);
        end
    endfunction

    task automatic drive(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input bit mr, input bit br,
                         input bit req, input bit rdy, input string tag);
        exp_t e;
        bit lu;
        rst                = r;
        hz.IF_ID_rs1       = rs1;
        hz.IF_ID_rs2       = rs2;
        hz.ID_EX_rd        = rd;
        hz.ID_EX_memRead   = mr;
        hz.EX_branch_taken = br;
        hz.dmem_req        = req;
        hz.dmem_ready      = rdy;
        e.tag = tag;
        e.stl = m_stl;
        e.fl  = m_fl;
        e.frz = m_frz;
        e.en = 5'b11111; e.flush = 0; e.bubble = 0; e.tmo = 0; e.st = 2'd0;
        lu = mr && (rd != 5'd0) && (rs1 == rd || rs2 == rd);
        if (r) begin
            e.en = 5'b00000;
            m_hung = 0; m_waiting = 0; m_frozen = 0;
            m_stl = 0; m_fl = 0; m_frz = 0;
        end else if (m_hung) begin
            e.en = 5'b00000; e.tmo = 1; e.st = 2'd2;
            m_frz++;
        end else begin
            e.st = m_waiting ? 2'd1 : 2'd0;
            if (!rdy && (m_waiting || req)) begin
                e.en = 5'b00000;
                m_frozen++;
                m_frz++;
                if (m_frozen >= MAX_WAIT) m_hung = 1;
                else m_waiting = 1;
            end else begin
                m_waiting = 0;
                m_frozen  = 0;
                if (br) begin
                    e.flush = 1; e.bubble = 1;
                    m_fl++;
                end else if (lu) begin
                    e.en = 5'b00111; e.bubble = 1;
                    m_stl++;
                end
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, tag);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("enables", me.tag, 32'({hz.pc_en, hz.if_id_en, hz.id_ex_en,
                                        hz.ex_mem_en, hz.mem_wb_en}), 32'(me.en));
            chk("if_id_flush", me.tag, 32'(hz.if_id_flush), 32'(me.flush));
            chk("id_ex_bubble", me.tag, 32'(hz.id_ex_bubble), 32'(me.bubble));
            chk("mem_timeout", me.tag, 32'(hz.mem_timeout), 32'(me.tmo));
            chk("state_dbg", me.tag, 32'(hz.state_dbg), 32'(me.st));
`ifdef PIPE_PERF_CNT_EN
            chk("stall_cycles", me.tag, hz.stall_cycles, me.stl);
            chk("flush_count", me.tag, hz.flush_count, me.fl);
            chk("freeze_cycles", me.tag, hz.freeze_cycles, me.frz);
`endif
        end
    end

    initial begin
        rst = 1'b1;
        hz.IF_ID_rs1 = 0; hz.IF_ID_rs2 = 0; hz.ID_EX_rd = 0; hz.ID_EX_memRead = 0;
        hz.EX_branch_taken = 0; hz.dmem_req = 0; hz.dmem_ready = 0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset holds everything off even with events present
        drive(1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0, "reset");
        idle("post_reset");

        // Load-use: one bubble, then the hazard clears
        drive(0, 5'd7, 5'd5, 5'd5, 1, 0, 0, 0, "load_use");
        drive(0, 5'd7, 5'd5, 5'd9, 0, 0, 0, 0, "load_use_after");
        drive(0, 5'd0, 5'd3, 5'd0, 1, 0, 0, 0, "x0_rd");
        drive(0, 5'd5, 5'd3, 5'd5, 0, 0, 0, 0, "no_load");
        drive(0, 5'd5, 5'd3, 5'd5, 1, 1, 0, 0, "branch_over_load_use");

        // Memory wait with branch held: frozen, then release shows flush
        drive(0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, "mem_wait_0");
        drive(0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, "mem_wait_1");
        drive(0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 0, "mem_wait_2");
        drive(0, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1, "mem_release");
        idle("mem_after");

        // Timeout: ready never comes, then ignored once hung
        for (int i = 0; i < MAX_WAIT; i++) drive(0, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0, "to_wait");
        drive(0, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, "to_hung_ready");
        drive(0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 1, "to_hung_idle");
        drive(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, "to_reset");
        idle("to_after_reset");

        // Counter scenario: 2 stalls, 1 flush, 3 frozen cycles
        drive(0, 5'd4, 5'd1, 5'd4, 1, 0, 0, 0, "perf_stall0");
        drive(0, 5'd2, 5'd6, 5'd6, 1, 0, 0, 0, "perf_stall1");
        drive(0, 5'd2, 5'd6, 5'd6, 0, 1, 0, 0, "perf_flush");
        drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, "perf_frz0");
        drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, "perf_frz1");
        drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, "perf_frz2");
        drive(0, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1, "perf_release");
        idle("perf_read");
        drive(1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, "perf_reset");
        idle("perf_cleared");

        // Random traffic on a small register set so hazards are frequent
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 63) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) < 6,
                  "random");
        end

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
